psg_sample_out: RTL and testbench
=================================

# psg_sample_out

Audio sample output stage for the PSG. Sits directly downstream of the fractional clock divider: it consumes the divider's one-cycle audio sample strobe, pops one stereo sample per strobe from an internal FIFO filled by the PSG mixer, and serialises it as left-justified I2S-style data (BCK/WS/SD) toward the audio DAC.

## Interface

**Parameters**
- `WIDTH`, 16: bits per channel.
- `DEPTH`, 16: FIFO depth in stereo samples. Must be a power of 2 and ≥ 2.
- `BCK_HALF`, 2: `clk_i` cycles per half bit-clock period. Must be ≥ 1.

**Ports**
- `clk_i`, in, 1: system clock. This is the only clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `sample_stb_i`, in, 1: one-cycle sample strobe from the divider.
- `s_data_i`, in, 2*WIDTH: {left, right}. Left is in the upper half.
- `s_valid_i`, in, 1: mixer offers a sample.
- `s_ready_o`, out, 1: FIFO can accept. Equals `level != DEPTH`.
- `fifo_level_o`, out, $clog2(DEPTH)+1: samples currently stored.
- `i2s_bck_o`, out, 1: bit clock.
- `i2s_ws_o`, out, 1: word select. 0 = left, 1 = right.
- `i2s_sd_o`, out, 1: serial data, MSB first.
- `underrun_o`, out, 1: one-cycle pulse when a strobe is accepted while the FIFO is empty.
- `late_o`, out, 1: one-cycle pulse when a strobe arrives while a frame is still shifting.

## Operation

**FIFO**
- A write occurs when `s_valid_i && s_ready_o`.
- The FIFO has no fall-through. A sample pushed in cycle N is not poppable until N+1.
- A push and a pop in the same cycle leave the level unchanged.
- Pointers wrap modulo DEPTH.

**Held sample register (HOLD)**
- HOLD stores the last sample popped. Reset value is 0.
- On underrun, the frame re-sends HOLD, so there is no zero-step click.

**States**
- **IDLE.** Outputs are `bck=0`, `ws=0`, `sd=0`. On `sample_stb_i`:
  - If the FIFO is not empty, pop into SR and HOLD.
  - If the FIFO is empty, load SR from HOLD and pulse `underrun_o`.
  - Then go to SHIFT with `half_cnt=0` and `bit_cnt=0`.
- **SHIFT.**
  - `half_cnt` counts 0..BCK_HALF-1. On wrap, `bck` toggles.
  - On each 1→0 `bck` transition:
    - SR shifts left by one.
    - `bit_cnt` increments.
  - `sd_o` = SR MSB.
  - `ws_o` = (`bit_cnt` ≥ WIDTH).
  - On the 1→0 transition that makes `bit_cnt == 2*WIDTH`, go to IDLE. Outputs return to IDLE values.
  - `sample_stb_i` in SHIFT pulses `late_o` and is otherwise ignored: no pop, and the frame is not restarted.

**Simultaneous and boundary events**
- Strobe with empty FIFO plus a push in the same cycle: counts as underrun. The pushed sample is stored and used at the next strobe.
- Full FIFO: `s_ready_o=0`, and `s_valid_i` is ignored.
- `reset_i` asserted at any point, including mid-frame:
  - Next cycle: IDLE, all outputs 0, `fifo_level_o=0`, HOLD=0.
  - `s_ready_o=1` from the first cycle after reset.
  - A strobe during reset is dropped.

## Timing

- Strobe accepted at cycle N → first bit on `i2s_sd_o` at N+1, with `ws=0` and `bck=0`.
- Each bit lasts 2*BCK_HALF cycles: low half first, then high half. SD and WS change only coincident with a `bck` falling edge (or frame start).
- Frame length is 2*WIDTH*2*BCK_HALF cycles (default 128). IDLE is reached at N+1+frame length.
- A strobe is accepted on the cycle the block re-enters IDLE.
- `fifo_level_o` and `s_ready_o` update one cycle after a push or pop.
- Strobe period must be ≥ frame length + 1. Violations are reported only via `late_o`.
- `underrun_o` and `late_o` assert in the cycle after the strobe.

## Test plan

1. **Reset values.** Hold reset for 3 cycles → all outputs 0 except `s_ready_o=1`. `fifo_level_o=0`.
2. **Single frame.** Push {16'hA5C3, 16'h0F01}, then strobe → starting at N+1, SD carries 1010_0101_1100_0011 with WS=0, then 0000_1111_0000_0001 with WS=1. Each bit lasts 4 cycles (bck low 2, high 2). IDLE at N+129. `fifo_level_o` goes 1→0 at N+1.
3. **Fill/full.** Push 17 samples back-to-back → `s_ready_o` drops after the 16th. The 17th is not accepted and `fifo_level_o=16`. 16 strobes spaced 200 cycles apart drain the samples in push order.
4. **Underrun.** Play sample {16'h1234, 16'h5678}, then strobe with the FIFO empty → `underrun_o` pulses once and the same 32 bits are re-sent.
5. **Late strobe.** Strobe at N and again at N+60 → `late_o` pulses at N+61. Frame bits are unchanged and the level is unchanged.
6. **Reset mid-frame.** Assert reset at N+40 with 3 samples queued → at N+41 all outputs are 0 and `fifo_level_o=0`. The next strobe with the FIFO empty sends 32 zero bits and pulses `underrun_o`.

Source files
------------

// File: rtl/psg_sample_out.sv
// PSG audio output stage: stereo sample FIFO feeding a left-justified I2S
// serialiser that emits one frame per divider sample strobe.
module psg_sample_out #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int BCK_HALF = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       sample_stb_i,
  input  logic [2*WIDTH-1:0]         s_data_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o,
  output logic                       i2s_bck_o,
  output logic                       i2s_ws_o,
  output logic                       i2s_sd_o,
  output logic                       underrun_o,
  output logic                       late_o
);

  localparam int SW = 2 * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(SW) + 1;
  localparam int HW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

  localparam logic [HW-1:0] HALF_LAST = HW'(BCK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SW - 1);
  localparam logic [BW-1:0] BIT_WS    = BW'(WIDTH);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          bck_q, bck_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [SW-1:0] hold_q, hold_d;
  logic          underrun_q, underrun_d;
  logic          late_q, late_d;

  logic [SW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic          push;
  logic          pop;
  logic          fifo_empty;

  // Level is registered, so a sample written this cycle cannot be popped until the next.
  assign fifo_empty = (level_q == '0);
  assign push       = s_valid_i && (level_q != LVL_FULL);
  assign pop        = (state_q == ST_IDLE) && sample_stb_i && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    bit_d      = bit_q;
    bck_d      = bck_q;
    sr_d       = sr_q;
    hold_d     = hold_q;
    underrun_d = 1'b0;
    late_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_stb_i) begin
          // An empty FIFO replays the last sample to avoid a step to zero.
          if (!fifo_empty) begin
            sr_d   = mem_q[rd_ptr_q];
            hold_d = mem_q[rd_ptr_q];
          end else begin
            sr_d       = hold_q;
            underrun_d = 1'b1;
          end
          state_d = ST_SHIFT;
          half_d  = '0;
          bit_d   = '0;
          bck_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        late_d = sample_stb_i;
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (bck_q) begin
            bck_d = 1'b0;
            sr_d  = {sr_q[SW-2:0], 1'b0};
            bit_d = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              state_d = ST_IDLE;
            end
          end else begin
            bck_d = 1'b1;
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      half_q     <= '0;
      bit_q      <= '0;
      bck_q      <= 1'b0;
      sr_q       <= '0;
      hold_q     <= '0;
      underrun_q <= 1'b0;
      late_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      bck_q      <= bck_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
      late_q     <= late_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  assign s_ready_o    = (level_q != LVL_FULL);
  assign fifo_level_o = level_q;
  assign i2s_bck_o    = bck_q;
  assign i2s_sd_o     = (state_q == ST_SHIFT) && sr_q[SW-1];
  assign i2s_ws_o     = (state_q == ST_SHIFT) && (bit_q >= BIT_WS);
  assign underrun_o   = underrun_q;
  assign late_o       = late_q;

endmodule

// File: tb/tb_psg_sample_out.sv
// Randomised scoreboard bench for psg_sample_out: a queue-based sample model
// predicts frames and pulse events; a monitor decodes the serial stream.
module tb_psg_sample_out;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 16;
  localparam int BCK_HALF  = 2;
  localparam int FRAME_LEN = 2 * WIDTH * 2 * BCK_HALF;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        sample_stb_i = 1'b0;
  logic [31:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [4:0]  fifo_level_o;
  logic        i2s_bck_o, i2s_ws_o, i2s_sd_o, underrun_o, late_o;

  always #5 clk = ~clk;

  psg_sample_out #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BCK_HALF(BCK_HALF)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .sample_stb_i (sample_stb_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .fifo_level_o (fifo_level_o),
    .i2s_bck_o    (i2s_bck_o),
    .i2s_ws_o     (i2s_ws_o),
    .i2s_sd_o     (i2s_sd_o),
    .underrun_o   (underrun_o),
    .late_o       (late_o)
  );

  // Reference model state
  logic [31:0] fifo_m[$];
  logic [31:0] hold_m = '0;
  int          last_acc = -1000000;
  int          cyc = 0;
  logic [31:0] exp_frames[$];
  int          exp_evt[$];   // 0 = underrun, 1 = late
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  // Applies one clock cycle of stimulus to the model, using start-of-cycle state.
  task automatic model_cycle(input logic rst, input logic stb, input logic vld, input logic [31:0] d);
    bit ready, empty;
    if (rst) begin
      if (cyc - last_acc < FRAME_LEN - 1) void'(exp_frames.pop_back());
      fifo_m.delete();
      hold_m   = '0;
      last_acc = -1000000;
    end else begin
      ready = (fifo_m.size() != DEPTH);
      empty = (fifo_m.size() == 0);
      if (stb) begin
        if (cyc - last_acc > FRAME_LEN) begin
          last_acc = cyc;
          if (!empty) hold_m = fifo_m.pop_front();
          else exp_evt.push_back(0);
          exp_frames.push_back(hold_m);
        end else begin
          exp_evt.push_back(1);
        end
      end
      if (vld && ready) fifo_m.push_back(d);
    end
  endtask

  task automatic step(input logic rst, input logic stb, input logic vld, input logic [31:0] d);
    @(negedge clk);
    reset_i      = rst;
    sample_stb_i = stb;
    s_valid_i    = vld;
    s_data_i     = d;
    model_cycle(rst, stb, vld, d);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic sample_point();
    @(posedge clk);
    #1;
  endtask

  task automatic check_level(input string tag);
    chk({tag, "_level"}, 32'(fifo_level_o), 32'(fifo_m.size()));
    chk({tag, "_ready"}, 32'(s_ready_o), 32'(fifo_m.size() != DEPTH));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_bck"}, 32'(i2s_bck_o), 32'h0);
    chk({tag, "_ws"}, 32'(i2s_ws_o), 32'h0);
    chk({tag, "_sd"}, 32'(i2s_sd_o), 32'h0);
    chk({tag, "_underrun"}, 32'(underrun_o), 32'h0);
    chk({tag, "_late"}, 32'(late_o), 32'h0);
  endtask

  // Monitor: decodes bits at each rising bck and checks pulses against the event queue.
  initial begin : monitor
    int          nbits;
    int          hi_cnt;
    logic        bck_prev;
    logic [31:0] sdw, wsw, expf;
    int          kind;
    nbits = 0; hi_cnt = 0; bck_prev = 1'b0; sdw = '0; wsw = '0;
    forever begin
      @(posedge clk);
      #1;
      if (underrun_o === 1'b1 || late_o === 1'b1) begin
        if (exp_evt.size() == 0) begin
          fail_now("evt_unexpected", $sformatf("underrun=%b late=%b with none pending", underrun_o, late_o));
        end else begin
          kind = exp_evt.pop_front();
          chk("evt_kind", {30'h0, underrun_o, late_o}, (kind == 0) ? 32'h2 : 32'h1);
        end
      end
      if (reset_i === 1'b1) begin
        nbits = 0; hi_cnt = 0; bck_prev = 1'b0;
      end else if (i2s_bck_o === 1'b1) begin
        if (!bck_prev) begin
          sdw = {sdw[30:0], i2s_sd_o};
          wsw = {wsw[30:0], i2s_ws_o};
          nbits++;
          if (nbits == 32) begin
            nbits = 0;
            if (exp_frames.size() == 0) begin
              fail_now("frame_unexpected", $sformatf("got %h with none pending", sdw));
            end else begin
              expf = exp_frames.pop_front();
              chk("frame_sd", sdw, expf);
              chk("frame_ws", wsw, 32'h0000FFFF);
            end
          end
        end
        hi_cnt++;
        bck_prev = 1'b1;
      end else begin
        if (bck_prev) chk("bck_high_len", 32'(hi_cnt), 32'(BCK_HALF));
        hi_cnt   = 0;
        bck_prev = 1'b0;
      end
    end
  end

  initial begin : stimulus
    logic [31:0] d;
    int          r;
    logic        rst, stb, vld;

    // Reset held 3 cycles with a strobe that must be dropped
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    sample_point();
    check_quiet("reset");
    check_level("reset");
    idle(2);

    // Single frame
    step(1'b0, 1'b0, 1'b1, 32'hA5C30F01);
    sample_point();
    check_level("single_push");
    step(1'b0, 1'b1, 1'b0, 32'h0);
    sample_point();
    check_level("single_pop");
    chk("first_bit_sd", 32'(i2s_sd_o), 32'h1);
    chk("first_bit_ws", 32'(i2s_ws_o), 32'h0);
    chk("first_bit_bck", 32'(i2s_bck_o), 32'h0);
    idle(140);

    // Fill to full, then drain in order
    for (int i = 0; i < 17; i++) begin
      d = $urandom;
      step(1'b0, 1'b0, 1'b1, d);
      sample_point();
      check_level("fill");
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      idle(199);
    end
    sample_point();
    check_level("drained");

    // Underrun replays the held sample
    step(1'b0, 1'b0, 1'b1, 32'h12345678);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(199);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(199);
    // Strobe on empty FIFO coincident with a push
    d = $urandom;
    step(1'b0, 1'b1, 1'b1, d);
    sample_point();
    check_level("stb_push");
    idle(199);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(199);

    // Late strobe
    step(1'b0, 1'b0, 1'b1, $urandom);
    step(1'b0, 1'b0, 1'b1, $urandom);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(59);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    sample_point();
    check_level("late");
    idle(200);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(200);

    // Reset mid-frame with samples queued
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, $urandom);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(39);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    sample_point();
    check_quiet("midreset");
    check_level("midreset");
    idle(5);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(200);

    // Randomised traffic with occasional resets and late strobes
    for (int i = 0; i < 4000; i++) begin
      r   = $urandom_range(0, 999);
      rst = (r < 2);
      stb = ($urandom_range(0, 149) == 0);
      vld = ($urandom_range(0, 2) == 0);
      step(rst, stb, vld, $urandom);
      sample_point();
      check_level("rand");
    end
    idle(300);
    sample_point();

    chk("frames_left", 32'(exp_frames.size()), 32'h0);
    chk("events_left", 32'(exp_evt.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
